if_fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register of the MIPS core. It owns the PC, issues word fetches to instruction memory over a req/ready handshake, and absorbs memory wait states and pipeline stalls. It redirects on jump or taken branch and presents the fetched instruction to decode. Its opcode output drives the control unit directly.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/if_id_register.sv | 36 +++
 rtl/if_fetch_stage.sv | 152 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width, reset PC, NOP encoding,
// instruction field positions and fetch-stage state encoding.
package mips_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned OPCODE_MSB   = 31;
    localparam int unsigned OPCODE_LSB   = 26;
    localparam int unsigned OPCODE_W     = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned JUMP_INDEX_W = 26;
    localparam int unsigned PC_UPPER_W   = 4;

    localparam logic [DATA_WIDTH-1:0] PC_RESET = 32'h0040_0000;
    localparam logic [DATA_WIDTH-1:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetchStateT;

    // J-type target: upper PC bits of the delay-slot address, word index, byte offset zero.
    function automatic logic [DATA_WIDTH-1:0] jumpTarget(
        input logic [PC_UPPER_W-1:0]   pcUpper,
        input logic [JUMP_INDEX_W-1:0] index
    );
        return {pcUpper, index, 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: instruction, its PC+4 and a valid flag.
// Flush has priority over load; hold when neither is asserted.
import mips_pkg::*;

module if_id_register #(
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = NOP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] nextInstr,
    input  logic [DATA_WIDTH-1:0] nextPcPlus4,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pcPlus4,
    output logic                  valid
);

    // Pipeline register with bubble injection on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr   <= NOP_INSTR;
            pcPlus4 <= '0;
            valid   <= 1'b0;
        end else if (flush) begin
            instr   <= NOP_INSTR;
            pcPlus4 <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= nextInstr;
            pcPlus4 <= nextPcPlus4;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem req/ready handshake,
// absorbs wait states and stalls via a one-entry skid, redirects on jump or
// taken branch, and feeds the IF/ID register.
import mips_pkg::*;

module if_fetch_stage #(
    parameter logic [DATA_WIDTH-1:0] PC_RESET = mips_pkg::PC_RESET,
    parameter logic [DATA_WIDTH-1:0] NOP      = mips_pkg::NOP
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  jump,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic [OPCODE_W-1:0]   opcode
);

    fetchStateT            state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcPlus4;
    logic [DATA_WIDTH-1:0] dropAddr;
    logic [DATA_WIDTH-1:0] skidInstr;
    logic [DATA_WIDTH-1:0] skidPcPlus4;

    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirectTarget;

    logic                  ifIdLoad;
    logic                  ifIdFlush;
    logic [DATA_WIDTH-1:0] ifIdNextInstr;
    logic [DATA_WIDTH-1:0] ifIdNextPcPlus4;

    assign pcPlus4  = pc + DATA_WIDTH'(4);
    assign redirect = jump | branch_taken;

    // Jump has priority over a simultaneously taken branch.
    assign redirectTarget = jump
        ? jumpTarget(if_id_pc_plus4[DATA_WIDTH-1 -: PC_UPPER_W], if_id_instr[JUMP_INDEX_W-1:0])
        : branch_target;

    // Request is idle only while the skid is full; forced low while in reset.
    assign imem_req  = reset && (state != HOLD);
    // A dropped request keeps its original address until memory answers.
    assign imem_addr = (state == DROP) ? dropAddr : pc;
    assign opcode    = if_id_instr[OPCODE_MSB:OPCODE_LSB];

    // IF/ID control: redirect flushes, otherwise load from memory or skid.
    always_comb begin
        ifIdLoad        = 1'b0;
        ifIdFlush       = 1'b0;
        ifIdNextInstr   = imem_rdata;
        ifIdNextPcPlus4 = pcPlus4;
        if (redirect) begin
            ifIdFlush = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            ifIdLoad = 1'b1;
                        end else begin
                            ifIdFlush = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifIdLoad        = 1'b1;
                        ifIdNextInstr   = skidInstr;
                        ifIdNextPcPlus4 = skidPcPlus4;
                    end
                end
                DROP: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Fetch FSM with PC, skid entry and dropped-request address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= PC_RESET;
            dropAddr    <= PC_RESET;
            skidInstr   <= NOP;
            skidPcPlus4 <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc <= redirectTarget;
                        if (!imem_ready) begin
                            dropAddr <= pc;
                            state    <= DROP;
                        end
                    end else if (imem_ready) begin
                        pc <= pcPlus4;
                        if (stall) begin
                            skidInstr   <= imem_rdata;
                            skidPcPlus4 <= pcPlus4;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= redirectTarget;
                        state <= FETCH;
                    end else if (!stall) begin
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc <= redirectTarget;
                    end
                    if (imem_ready) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP)
    ) u_if_id_register (
        .clk         (clk),
        .reset       (reset),
        .load        (ifIdLoad),
        .flush       (ifIdFlush),
        .nextInstr   (ifIdNextInstr),
        .nextPcPlus4 (ifIdNextPcPlus4),
        .instr       (if_id_instr),
        .pcPlus4     (if_id_pc_plus4),
        .valid       (if_id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, streaming, wait states, stall/skid,
// jump-over-branch priority, dropped request and asynchronous reset in DROP.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [5:0]  opcode;

    int errors = 0;
    int checks = 0;

    // Memory model: a J instruction at 0x00400004, address-tagged LW words elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0040_0004) return 32'h0810_0010;
        return {16'h8C00, a[15:0]};
    endfunction

    assign imem_rdata = memWord(imem_addr);

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .jump           (jump),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .opcode         (opcode)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc4);
        check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
        check({tag, ".instr"}, if_id_instr, ins);
        check({tag, ".pc4"}, if_id_pc_plus4, pc4);
        check({tag, ".opcode"}, 32'(opcode), 32'(ins[31:26]));
    endtask

    task automatic checkFetch(input string tag, input logic rq, input logic [31:0] addr);
        check({tag, ".req"}, 32'(imem_req), 32'(rq));
        if (rq) check({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst.req", 32'(imem_req), 32'h0);
        checkIfId("rst", 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_hold.req", 32'(imem_req), 32'h0);
        check("rst_hold.valid", 32'(if_id_valid), 32'h0);
        reset = 1'b1;
        #1;
        checkFetch("rel", 1'b1, 32'h0040_0000);

        // Streaming at one instruction per cycle
        tick();
        checkFetch("s1", 1'b1, 32'h0040_0004);
        checkIfId("s1", 1'b1, 32'h8C00_0000, 32'h0040_0004);
        tick();
        checkFetch("s2", 1'b1, 32'h0040_0008);
        checkIfId("s2", 1'b1, 32'h0810_0010, 32'h0040_0008);

        // Two wait states at 0x00400008
        imem_ready = 1'b0;
        tick();
        checkFetch("w1", 1'b1, 32'h0040_0008);
        checkIfId("w1", 1'b0, 32'h0, 32'h0);
        tick();
        checkFetch("w2", 1'b1, 32'h0040_0008);
        checkIfId("w2", 1'b0, 32'h0, 32'h0);
        imem_ready = 1'b1;
        tick();
        checkFetch("w3", 1'b1, 32'h0040_000C);
        checkIfId("w3", 1'b1, 32'h8C00_0008, 32'h0040_000C);

        // Stall three cycles with ready high: one word parked in the skid
        stall = 1'b1;
        tick();
        checkFetch("st1", 1'b0, 32'h0);
        checkIfId("st1", 1'b1, 32'h8C00_0008, 32'h0040_000C);
        tick();
        checkFetch("st2", 1'b0, 32'h0);
        tick();
        checkFetch("st3", 1'b0, 32'h0);
        checkIfId("st3", 1'b1, 32'h8C00_0008, 32'h0040_000C);
        stall = 1'b0;
        tick();
        checkFetch("st4", 1'b1, 32'h0040_0010);
        checkIfId("st4", 1'b1, 32'h8C00_000C, 32'h0040_0010);
        tick();
        checkFetch("st5", 1'b1, 32'h0040_0014);
        checkIfId("st5", 1'b1, 32'h8C00_0010, 32'h0040_0014);

        // Jump with simultaneous taken branch: jump wins
        reset = 1'b0;
        #1;
        checkFetch("jr", 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        tick();
        checkIfId("j1", 1'b1, 32'h8C00_0000, 32'h0040_0004);
        tick();
        checkIfId("j2", 1'b1, 32'h0810_0010, 32'h0040_0008);
        jump = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h0040_0100;
        tick();
        checkFetch("j3", 1'b1, 32'h0040_0040);
        check("j3.valid", 32'(if_id_valid), 32'h0);
        check("j3.instr", if_id_instr, 32'h0);
        jump = 1'b0;
        branch_taken = 1'b0;
        tick();
        checkFetch("j4", 1'b1, 32'h0040_0044);
        checkIfId("j4", 1'b1, 32'h8C00_0040, 32'h0040_0044);

        // Branch while fetch to 0x00400010 waits: request held, data dropped
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checkFetch("b0", 1'b1, 32'h0040_0010);
        imem_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0040_0200;
        tick();
        checkFetch("b1", 1'b1, 32'h0040_0010);
        check("b1.valid", 32'(if_id_valid), 32'h0);
        branch_taken = 1'b0;
        tick();
        checkFetch("b2", 1'b1, 32'h0040_0010);
        check("b2.valid", 32'(if_id_valid), 32'h0);
        imem_ready = 1'b1;
        tick();
        checkFetch("b3", 1'b1, 32'h0040_0200);
        check("b3.valid", 32'(if_id_valid), 32'h0);
        tick();
        checkFetch("b4", 1'b1, 32'h0040_0204);
        checkIfId("b4", 1'b1, 32'h8C00_0200, 32'h0040_0204);

        // Second redirect while dropping updates the PC only
        imem_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0040_0300;
        tick();
        checkFetch("d1", 1'b1, 32'h0040_0204);
        branch_target = 32'h0040_0400;
        tick();
        checkFetch("d2", 1'b1, 32'h0040_0204);
        branch_taken = 1'b0;
        imem_ready = 1'b1;
        tick();
        checkFetch("d3", 1'b1, 32'h0040_0400);
        check("d3.valid", 32'(if_id_valid), 32'h0);

        // Enter DROP again, then assert reset between clock edges
        imem_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0040_0500;
        tick();
        checkFetch("d4", 1'b1, 32'h0040_0400);
        branch_taken = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkFetch("ar", 1'b0, 32'h0);
        check("ar.addr", imem_addr, 32'h0040_0000);
        checkIfId("ar", 1'b0, 32'h0, 32'h0);
        imem_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        checkFetch("ar_rel", 1'b1, 32'h0040_0000);
        tick();
        checkFetch("ar1", 1'b1, 32'h0040_0004);
        checkIfId("ar1", 1'b1, 32'h8C00_0000, 32'h0040_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
